fifomult_gen: RTL and testbench

FIFOMULT_GEN -- requirements
Module: fifomult_gen

---
 rtl/fifomult_gen.sv | 189 ++++++++++++++++++
 tb/tb_fifomult_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fifomult_gen.sv
// Operand-group multiplier: collects N_OPS parity-checked operands, multiplies them
// over N_OPS-1 cycles and queues {product, error} in an output FIFO. Macro FIFOMULT_GEN_SIGNED_EN selects signed math.
module fifomult_gen #(
  parameter int DATA_W    = 16,
  parameter int N_OPS     = 2,
  parameter int OUT_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      data_in_parity,
  input  logic                      data_in_valid,
  output logic                      busy_out,
  output logic [N_OPS*DATA_W-1:0]   data_out,
  output logic                      data_out_parity,
  output logic                      data_out_valid,
  input  logic                      data_out_ready,
  output logic                      data_in_parity_error
);

  localparam int RES_W = N_OPS * DATA_W;
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = $clog2(N_OPS);
  localparam int ENT_W = RES_W + 1;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_MUL     = 2'd1,
    S_PUSH    = 2'd2
  } state_t;

  function automatic logic parity_f(input logic [RES_W-1:0] v);
    return ^v;
  endfunction

  function automatic logic [RES_W-1:0] extend_f(input logic [DATA_W-1:0] v);
`ifdef FIFOMULT_GEN_SIGNED_EN
    return {{(RES_W-DATA_W){v[DATA_W-1]}}, v};
`else
    return {{(RES_W-DATA_W){1'b0}}, v};
`endif
  endfunction

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [DATA_W-1:0]      r_ops [N_OPS];
  logic [RES_W-1:0]       r_acc;
  logic                   r_err;
  logic [ENT_W-1:0]       r_mem [OUT_DEPTH];
  logic [PTR_W:0]         r_wptr;
  logic [PTR_W:0]         r_rptr;

  logic                   w_accept;
  logic                   w_perr;
  logic                   w_last_op;
  logic                   w_last_mul;
  logic [CNT_W-1:0]       w_mul_idx;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic [RES_W-1:0]       w_result;
  logic [ENT_W-1:0]       w_head;

  assign w_accept   = data_in_valid && (r_state == S_COLLECT);
  assign w_perr     = parity_f(RES_W'(data_in)) ^ data_in_parity;
  assign w_last_op  = (r_cnt == CNT_W'(N_OPS - 1));
  assign w_last_mul = (r_cnt == CNT_W'(N_OPS - 2));
  assign w_mul_idx  = r_cnt + CNT_W'(1);
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                      (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_push     = (r_state == S_PUSH) && !w_full;
  assign w_pop      = !w_empty && data_out_ready;
  assign w_result   = r_err ? {RES_W{1'b0}} : r_acc;
  assign w_head     = r_mem[r_rptr[PTR_W-1:0]];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_COLLECT: begin
        if (w_accept && w_last_op) begin
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_COLLECT;
        end
      end
      S_MUL: begin
        if (w_last_mul) begin
          w_state_nxt = S_PUSH;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_PUSH: begin
        if (!w_full) begin
          w_state_nxt = S_COLLECT;
        end else begin
          w_state_nxt = S_PUSH;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // Operand capture, error accumulation and iterative multiply
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_err <= 1'b0;
      for (int i = 0; i < N_OPS; i++) begin
        r_ops[i] <= '0;
      end
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_ops[r_cnt] <= data_in;
            // The first operand seeds the accumulator and restarts the error flag
            if (r_cnt == '0) begin
              r_acc <= extend_f(data_in);
              r_err <= w_perr;
            end else begin
              r_err <= r_err | w_perr;
            end
            if (w_last_op) begin
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_MUL: begin
          // Full-width product of RES_W operands keeps the low RES_W bits, exact for both signednesses
          r_acc <= r_acc * extend_f(r_ops[w_mul_idx]);
          if (w_last_mul) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= w_mul_idx;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (PTR_W+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (PTR_W+1)'(1);
      end
    end
  end

  // FIFO storage; contents are masked at the outputs while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[PTR_W-1:0]] <= {w_result, r_err};
    end
  end

  assign busy_out             = (r_state != S_COLLECT);
  assign data_out_valid       = !w_empty;
  assign data_out             = w_empty ? {RES_W{1'b0}} : w_head[ENT_W-1:1];
  assign data_in_parity_error = w_empty ? 1'b0 : w_head[0];
  assign data_out_parity      = parity_f(data_out);

endmodule

// File: tb/tb_fifomult_gen.sv
// Randomised scoreboard bench for fifomult_gen (DATA_W=16, N_OPS=2, OUT_DEPTH=4).
module tb_fifomult_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'd0;
  logic        data_in_parity = 1'b0;
  logic        data_in_valid = 1'b0;
  logic        busy_out;
  logic [31:0] data_out;
  logic        data_out_parity;
  logic        data_out_valid;
  logic        data_out_ready = 1'b0;
  logic        data_in_parity_error;

  int          checks = 0;
  int          errors = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] exp_d [$];
  bit          exp_e [$];

  fifomult_gen #(.DATA_W(16), .N_OPS(2), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_parity(data_in_parity),
    .data_in_valid(data_in_valid), .busy_out(busy_out), .data_out(data_out),
    .data_out_parity(data_out_parity), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_in_parity_error(data_in_parity_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
`ifdef FIFOMULT_GEN_SIGNED_EN
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p  = sa * sb;
`else
    longint p  = longint'(a) * longint'(b);
`endif
    return p[31:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic send_op(input logic [15:0] v, input bit bad);
    int n = 0;
    @(posedge clk); #1;
    while (busy_out && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_out) chk("accept_timeout", 64'(busy_out), 64'd0);
    data_in        = v;
    data_in_parity = (^v) ^ bad;
    data_in_valid  = 1'b1;
    @(posedge clk); #1;
    data_in_valid  = 1'b0;
  endtask

  task automatic send_group(input logic [15:0] a, input logic [15:0] b, input bit bad_a, input bit bad_b);
    send_op(a, bad_a);
    send_op(b, bad_b);
    exp_e.push_back(bad_a | bad_b);
    exp_d.push_back((bad_a | bad_b) ? 32'd0 : model(a, b));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_d.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_d.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("no_extra_result", 64'(data_out_valid), 64'd0);
  endtask

  // Scoreboard monitor: compares the head whenever it is being popped
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_out_valid) begin
        if (data_out_ready) begin
          if (exp_d.size() == 0) begin
            chk("unexpected_result", 64'(data_out), 64'hDEAD);
          end else begin
            logic [31:0] ed;
            bit          ee;
            ed = exp_d.pop_front();
            ee = exp_e.pop_front();
            chk("data_out", 64'(data_out), 64'(ed));
            chk("data_out_parity", 64'(data_out_parity), 64'(^ed));
            chk("parity_error", 64'(data_in_parity_error), 64'(ee));
          end
        end
      end else begin
        chk("idle_outputs", {31'd0, data_out_parity, data_in_parity_error, data_out}, 64'd0);
      end
    end
  end

  // Random backpressure
  always @(posedge clk) begin
    #1;
    if (rand_ready) data_out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_valid", 64'(data_out_valid), 64'd0);
    chk("rst_data", 64'(data_out), 64'd0);
    chk("rst_parity", 64'(data_out_parity), 64'd0);
    chk("rst_err", 64'(data_in_parity_error), 64'd0);
    rst_n = 1'b1;

    // Basic product and latency
    data_out_ready = 1'b1;
    send_group(16'h0003, 16'h0005, 1'b0, 1'b0);
    @(negedge clk) chk("lat_t1", 64'(data_out_valid), 64'd0);
    @(negedge clk) chk("lat_t2", 64'(data_out_valid), 64'd0);
    @(negedge clk) chk("lat_t3", 64'(data_out_valid), 64'd1);
    drain();

    send_group(16'h0001, 16'h0002, 1'b1, 1'b0);
    drain();
    send_group(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    drain();

    // Full FIFO backpressure
    data_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_group(16'(i), 16'(i), 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("full_busy", 64'(busy_out), 64'd1);
    chk("full_valid", 64'(data_out_valid), 64'd1);
    data_out_ready = 1'b1;
    drain();

    // Reset discards a partial group
    send_op(16'h0007, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy_out), 64'd0);
    chk("midrst_valid", 64'(data_out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_group(16'h0002, 16'h0003, 1'b0, 1'b0);
    drain();

    // Random operands, parity faults and backpressure
    rand_ready = 1'b1;
    for (int g = 0; g < 40; g++) begin
      send_group(16'($urandom), 16'($urandom),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    data_out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
